// File: rtl/mag_sq_pkg.sv
// Shared types and sizing for the magnitude-squared feeder: FSM states,
// default component width and the bit-counter width derived from it.
package mag_sq_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_X = 2'd1,
    MUL_Y = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(W_DEFAULT);

endpackage

// File: rtl/seq_squarer.sv
// Serial shift-add squarer datapath: walks the multiplier bits of one operand
// LSB first and presents the partial product (operand << i) for the caller to accumulate.
module seq_squarer
  import mag_sq_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int CNT_W = cnt_width(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           step,
  input  logic [W-1:0]   operand,
  output logic [2*W-1:0] addend,
  output logic           done
);

  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0]   wide;

  // Counter wraps to 0 after the last bit so the next operand starts at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= done ? '0 : cnt + CNT_W'(1);
    end
  end

  always_comb begin
    wide   = {{W{1'b0}}, operand} << cnt;
    addend = operand[cnt] ? wide : '0;
    done   = step && (cnt == CNT_W'(W - 1));
  end

endmodule

// File: rtl/mag_sq_feeder.sv
// Computes x*x + y*y serially (W cycles per component) and hands the
// unsigned 2W-bit result to a downstream square-root stage with valid/ready.
module mag_sq_feeder
  import mag_sq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*W-1:0]      out_data,
  output logic                busy
);

  localparam int CNT_W = cnt_width(W);

  state_t         state, nxt;
  logic [W-1:0]   ax, ay;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] addend;
  logic [W-1:0]   operand;
  logic           start, step, sq_done;

  // Magnitude as W-bit unsigned; the most negative value maps to 2^(W-1).
  function automatic logic [W-1:0] abs_u(input logic signed [W-1:0] v);
    logic [W-1:0] t;
    t = v;
    return t[W-1] ? (~t + W'(1)) : t;
  endfunction

  assign start   = in_valid && in_ready;
  assign step    = (state == MUL_X) || (state == MUL_Y);
  assign operand = (state == MUL_Y) ? ay : ax;

  seq_squarer #(.W(W), .CNT_W(CNT_W)) u_sq (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .step    (step),
    .operand (operand),
    .addend  (addend),
    .done    (sq_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ax       <= '0;
      ay       <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      state <= nxt;
      if (start) begin
        ax  <= abs_u(x);
        ay  <= abs_u(y);
        acc <= '0;
      end else if (step) begin
        acc <= acc + addend;
      end
      // Result is captured once so it survives the accumulator clear of the next sample.
      if (state == MUL_Y && sq_done) begin
        out_data <= acc + addend;
      end
    end
  end

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) nxt = MUL_X;
      end
      MUL_X: if (sq_done) nxt = MUL_Y;
      MUL_Y: if (sq_done) nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mag_sq_feeder.sv
// Scoreboard bench for mag_sq_feeder: directed samples push expected sums and
// accept edges; a monitor checks latency and data whenever a result appears.
module tb_mag_sq_feeder;

  localparam int W = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] x = '0;
  logic signed [W-1:0] y = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [2*W-1:0]      out_data;
  logic                busy;

  mag_sq_feeder #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int results = 0;
  logic [2*W-1:0] exp_q[$];
  int             edge_q[$];
  logic           prev_v = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on each rising out_valid, data on each output handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (edge_q.size() == 0) chk("spurious_out_valid", 1, 0);
        else chk("latency", cyc - edge_q.pop_front(), 2 * W);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          chk("out_data", out_data, exp_q.pop_front());
          results++;
        end
      end
      prev_v = out_valid;
    end
  end

  // Offers a sample, waits for acceptance, then scrambles x/y; in_valid stays high.
  task automatic send(input logic signed [W-1:0] sx, input logic signed [W-1:0] sy,
                      input logic [2*W-1:0] exp, input bit push, output int acc_edge);
    int n;
    @(negedge clk);
    x = sx;
    y = sy;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    acc_edge = cyc + 1;
    if (push) begin
      exp_q.push_back(exp);
      edge_q.push_back(acc_edge);
    end
    @(posedge clk);
    #1;
    x = W'($urandom);
    y = W'($urandom);
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  int e0, e1, e2;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;

    // 3,4 -> 25
    send(3, 4, 25, 1, e0);
    drain();
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    // Extremes
    send(-128, -128, 16'h8000, 1, e0);
    drain();
    send(0, 0, 0, 1, e0);
    drain();

    // Backpressure: result held, in_valid ignored while busy
    out_ready = 1'b0;
    send(-5, 12, 169, 1, e0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
    chk("hold_out_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk("hold_out_data", out_data, 169);
      chk("hold_in_ready", in_ready, 0);
      in_valid = ~in_valid;
      x = 8'sd100;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (20) @(negedge clk);
    chk("hold_single_result", results, 4);

    // Reset during MUL_Y discards the sample
    send(7, 7, 98, 0, e0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    repeat (30) @(negedge clk);

    // Back-to-back with in_valid held high
    send(4, 0, 16, 1, e0);
    send(0, 9, 81, 1, e1);
    send(1, 1, 2, 1, e2);
    drain();
    chk("spacing_1", e1 - e0, 2 * W + 2);
    chk("spacing_2", e2 - e1, 2 * W + 2);

    repeat (5) @(negedge clk);
    chk("result_count", results, 7);
    chk("edge_q_empty", edge_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
